rf_debug_port: RTL
==================

# rf_debug_port

Debug-side initiator for the OTTER register file. It accepts read, write and full-dump commands from the debug host over a valid/ready command stream while the CPU is halted. It drives the register file's debug-muxed read address and write port, and returns results on a valid/ready response stream. It sits between the debug transport and the register file port mux in the MCU top level.

## Interface
- XLEN, 32, data width of registers and of the command/response data.
- NREGS, 32, number of architectural registers; the address width is 5.
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CPU_HALTED  in  1  CPU is halted; the block may own the register file ports.
- CMD_VALID  in  1  / CMD_READY  out  1  command handshake.
- CMD_OP  in  2  00 read, 01 write, 10 dump all, 11 reserved.
- CMD_ADR  in  5  target register for read/write; ignored for dump.
- CMD_DATA  in  XLEN  write data.
- RSP_VALID  out  1  / RSP_READY  in  1  response handshake.
- RSP_DATA  out  XLEN  read data, or echoed write data.
- RSP_ADR  out  5  register the response refers to.
- RSP_ERR  out  1  reserved opcode.
- RSP_LAST  out  1  final beat of a command.
- DBG_OWN  out  1  top level muxes the register file ports to this block when high.
- DBG_ADR  out  5  register file read address.
- DBG_RS  in  XLEN  asynchronous read data for DBG_ADR.
- DBG_WA  out  5  / DBG_WD  out  XLEN  / DBG_EN  out  1  register file write port.

## Operation
- FSM states: IDLE, READ, WRITE, DUMP_RD, DUMP_RSP, RESP.
- IDLE:
  - CMD_READY = CPU_HALTED (combinational); in every other state CMD_READY = 0.
  - On handshake, latch op, adr and data.
  - Next state: READ for 00, WRITE for 01, DUMP_RD for 10.
  - For 11, go to RESP with RSP_ERR=1, RSP_DATA=0, RSP_ADR=0, RSP_LAST=1.
- DBG_OWN = 1 in every state except IDLE. The halt controller must keep the CPU halted while DBG_OWN=1. CPU_HALTED is sampled only in IDLE.
- READ: DBG_ADR = latched adr for one cycle. At the closing edge, capture DBG_RS into RSP_DATA, set RSP_ADR = adr, RSP_LAST=1, RSP_ERR=0, and go to RESP.
- WRITE:
  - DBG_WA = adr, DBG_WD = data, and DBG_EN = 1 for exactly one cycle, except when adr = 0. For adr = 0, DBG_EN stays 0 and x0 is never written.
  - Then go to RESP with RSP_DATA = data, RSP_ADR = adr, RSP_LAST=1.
- DUMP:
  - A 5-bit index counter starts at 0.
  - DUMP_RD: DBG_ADR = idx. At the edge, capture DBG_RS and idx into RSP_DATA and RSP_ADR, set RSP_LAST = (idx == NREGS-1), and go to DUMP_RSP.
  - DUMP_RSP: hold RSP_VALID=1 until RSP_READY.
    - On handshake with LAST=0: idx+1, back to DUMP_RD.
    - On handshake with LAST=1: go to IDLE and clear idx to 0.
  - Idx never wraps within a dump. The x0 beat returns whatever the register file reports (0).
- RESP: RSP_VALID=1 and all RSP_* fields stable until RSP_READY, then go to IDLE.
- DBG_EN = 0 in every state except WRITE. DBG_WA, DBG_WD and DBG_ADR are don't-care when not driven, but are held at 0.

## Timing
- Reset:
  - State goes to IDLE and idx to 0.
  - RSP_VALID, RSP_ERR, RSP_LAST, DBG_OWN and DBG_EN go to 0; RSP_DATA, RSP_ADR, DBG_ADR, DBG_WA and DBG_WD go to 0.
  - Reset asserted mid-command aborts it: DBG_EN drops asynchronously, no write occurs, and the pending response is discarded.
- Read: command handshake at edge N. DBG_ADR is valid during cycle N..N+1. RSP_VALID rises after edge N+1, so latency is 2 edges.
- Write: DBG_EN is high for the one cycle after handshake edge N. The register file updates at edge N+1, and RSP_VALID rises after edge N+1.
- Dump: 2 cycles per beat with RSP_READY tied high. The 32 beats take 64 cycles from handshake to the last response handshake.
- Back-to-back commands: the next CMD_READY can assert the cycle after the final response handshake. There is no overlap.
- RSP_READY low stalls indefinitely with outputs held. No register file activity occurs while stalled.

## Test plan
- CPU_HALTED=0, CMD_VALID=1 -> CMD_READY stays 0 for 10 cycles and DBG_OWN stays 0.
- Halted: write x5=0xDEADBEEF, then read x5 -> write response RSP_DATA=0xDEADBEEF, RSP_ADR=5, LAST=1; read returns 0xDEADBEEF 2 edges after handshake.
- Write x0=0x12345678 -> DBG_EN never asserts and the response echoes the data. A subsequent read of x0 returns 0.
- Preload xi = i*4+1, dump with RSP_READY toggling every other cycle -> exactly 32 beats, RSP_ADR 0..31, data 0,5,9,...,125, LAST only on beat 31.
- CMD_OP=11 -> single response with RSP_ERR=1, RSP_DATA=0, LAST=1, and no DBG_EN.
- RST_N pulsed low during the DUMP beat for x10 -> all outputs go to reset values immediately, and the next dump restarts at x0.

Source files
------------

// File: rtl/rf_debug_port.sv
// Debug-side initiator for the register file: executes read, write and dump commands
// from the debug host while the CPU is halted and returns results on a response stream.
module rf_debug_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cpu_halted_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [4:0]      cmd_adr_i,
  input  logic [XLEN-1:0] cmd_data_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic [4:0]      rsp_adr_o,
  output logic            rsp_err_o,
  output logic            rsp_last_o,
  output logic            dbg_own_o,
  output logic [4:0]      dbg_adr_o,
  input  logic [XLEN-1:0] dbg_rs_i,
  output logic [4:0]      dbg_wa_o,
  output logic [XLEN-1:0] dbg_wd_o,
  output logic            dbg_en_o,
  output logic [2:0]      dbg_state_o
);

  // Both streams use valid/ready: a beat transfers on a rising edge where valid and
  // ready are both high; the sender holds valid and all payload fields until then.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WRITE    = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_RSP = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_e          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [4:0]      adr_q, adr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]      rsp_adr_q, rsp_adr_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_last_q, rsp_last_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      adr_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_adr_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_adr_q  <= rsp_adr_d;
      rsp_err_q  <= rsp_err_d;
      rsp_last_q <= rsp_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    adr_d       = adr_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_adr_d   = rsp_adr_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;
    cmd_ready_o = 1'b0;
    dbg_adr_o   = '0;
    dbg_wa_o    = '0;
    dbg_wd_o    = '0;
    dbg_en_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = cpu_halted_i;
        if (cmd_valid_i && cpu_halted_i) begin
          adr_d  = cmd_adr_i;
          data_d = cmd_data_i;
          case (cmd_op_i)
            2'b00: state_d = S_READ;
            2'b01: state_d = S_WRITE;
            2'b10: begin
              idx_d   = '0;
              state_d = S_DUMP_RD;
            end
            default: begin
              rsp_data_d = '0;
              rsp_adr_d  = '0;
              rsp_err_d  = 1'b1;
              rsp_last_d = 1'b1;
              state_d    = S_RESP;
            end
          endcase
        end
      end
      S_READ: begin
        dbg_adr_o  = adr_q;
        rsp_data_d = dbg_rs_i;
        rsp_adr_d  = adr_q;
        rsp_err_d  = 1'b0;
        rsp_last_d = 1'b1;
        state_d    = S_RESP;
      end
      S_WRITE: begin
        // x0 is architecturally zero, so the write strobe is suppressed for it.
        dbg_wa_o   = adr_q;
        dbg_wd_o   = data_q;
        dbg_en_o   = (adr_q != 5'd0);
        rsp_data_d = data_q;
        rsp_adr_d  = adr_q;
        rsp_err_d  = 1'b0;
        rsp_last_d = 1'b1;
        state_d    = S_RESP;
      end
      S_DUMP_RD: begin
        dbg_adr_o  = idx_q;
        rsp_data_d = dbg_rs_i;
        rsp_adr_d  = idx_q;
        rsp_err_d  = 1'b0;
        rsp_last_d = (idx_q == LAST_IDX);
        state_d    = S_DUMP_RSP;
      end
      S_DUMP_RSP: begin
        if (rsp_ready_i) begin
          if (rsp_last_q) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_DUMP_RD;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_valid_o = (state_q == S_RESP) || (state_q == S_DUMP_RSP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_adr_o   = rsp_adr_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_last_o  = rsp_last_q;
  assign dbg_own_o   = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
